input_conditioner: RTL and testbench

Parametrised, multi-channel input conditioning for asynchronous board inputs such as keys and switches. Each channel is processed in four steps:

- an N-stage flip-flop synchroniser;
- an optional polarity inversion;
- a consecutive-cycle debounce filter;
- a one-cycle rise/fall edge detector.

The block sits between the top-level pins and the controller logic. All downstream logic consumes only its clean, logically-asserted levels and single-cycle edge pulses.

---
 rtl/input_cond_pkg.sv | 10 +
 rtl/input_conditioner_if.sv | 13 +
 rtl/input_conditioner_debounce.sv | 92 +++++++++
 rtl/input_conditioner.sv | 38 +++
 tb/tb_input_conditioner.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the input conditioner and its per-channel debounce slice.
package input_cond_pkg;

    typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} deb_state_t;

    function automatic int cnt_width(int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side inputs and conditioned outputs of the input conditioner.
interface input_conditioner_if #(
    parameter int CHANNELS = 10
) ();
    logic                clear;
    logic [CHANNELS-1:0] in_raw;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    modport master (output clear, in_raw, input level, rise, fall);
    modport slave  (input clear, in_raw, output level, rise, fall);
endinterface

// File: rtl/input_conditioner_debounce.sv
// One channel: synchroniser, optional inversion, consecutive-cycle debounce and edge pulses.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic INVERT_BIT      = 1'b0,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic in_raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   cond, mismatch, commit;
    deb_state_t             state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= {SYNC_STAGES{RESET_BIT}};
            level_q <= RESET_BIT ^ INVERT_BIT;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], in_raw};
    assign cond     = sync_q[SYNC_STAGES-1] ^ INVERT_BIT;
    assign state    = (cnt_q == '0) ? STABLE : PENDING;
    assign mismatch = (cond != level_q);
    // The final mismatching cycle commits the new level instead of counting further.
    assign commit   = mismatch && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (clear) begin
            cnt_d   = '0;
            level_d = cond;
        end else begin
            case (state)
                STABLE: begin
                    if (commit)        level_d = cond;
                    else if (mismatch) cnt_d   = cnt_q + 1'b1;
                end
                PENDING: begin
                    if (!mismatch) begin
                        cnt_d = '0;
                    end else if (commit) begin
                        cnt_d   = '0;
                        level_d = cond;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // clear adopts the new level silently, so it never produces an edge pulse.
    always_comb begin
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (!clear && commit) begin
            rise_d = cond;
            fall_d = !cond;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel conditioner for asynchronous board inputs: one debounce_channel per pin.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int                  CHANNELS        = 10,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 4,
    parameter logic [CHANNELS-1:0] INVERT          = '0,
    parameter logic [CHANNELS-1:0] RESET_RAW       = '0
) (
    input logic                clock,
    input logic                reset_n,
    input_conditioner_if.slave bus
);
    logic [CHANNELS-1:0] level_w, rise_w, fall_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT_BIT      (INVERT[i]),
            .RESET_BIT       (RESET_RAW[i])
        ) u_ch (
            .clock   (clock),
            .reset_n (reset_n),
            .clear   (bus.clear),
            .in_raw  (bus.in_raw[i]),
            .level   (level_w[i]),
            .rise    (rise_w[i]),
            .fall    (fall_w[i])
        );
    end

    assign bus.level = level_w;
    assign bus.rise  = rise_w;
    assign bus.fall  = fall_w;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed plus randomized bench for input_conditioner against a history-based reference model.
module tb_input_conditioner;
    localparam int         CH  = 4;
    localparam int         S   = 2;
    localparam int         D   = 4;
    localparam logic [3:0] INV = 4'b0001;
    localparam logic [3:0] RR  = 4'b0001;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    input_conditioner_if #(.CHANNELS(CH)) bus ();

    input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .INVERT(INV), .RESET_RAW(RR)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: raw samples delayed by S edges, then a level flips once the last D
    // cond samples all disagree with it; clear adopts cond with no pulse.
    logic [3:0] sq[$];
    logic [3:0] hist[$];
    logic [3:0] m_level, m_rise, m_fall;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        sq.delete();
        repeat (S) sq.push_back(RR);
        m_level = RR ^ INV;
        hist.delete();
        repeat (D) hist.push_back(m_level);
        m_rise = '0;
        m_fall = '0;
    endtask

    task automatic m_step();
        logic [3:0] cond, nl;
        bit all;
        cond = sq.pop_front() ^ INV;
        sq.push_back(bus.in_raw);
        hist.push_back(cond);
        if (hist.size() > D) void'(hist.pop_front());
        nl = m_level;
        if (bus.clear) begin
            nl = cond;
        end else begin
            for (int b = 0; b < CH; b++) begin
                all = 1'b1;
                foreach (hist[k]) if (hist[k][b] == m_level[b]) all = 1'b0;
                if (all) nl[b] = cond[b];
            end
        end
        m_rise  = bus.clear ? 4'b0 : (nl & ~m_level);
        m_fall  = bus.clear ? 4'b0 : (~nl & m_level);
        m_level = nl;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) m_reset();
            else          m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                check("level", bus.level, m_level);
                check("rise",  bus.rise,  m_rise);
                check("fall",  bus.fall,  m_fall);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int c;
        bus.clear  = 1'b0;
        bus.in_raw = 4'b1110;
        #1;
        check("reset_level", bus.level, 4'b0000);
        check("reset_rise",  bus.rise,  4'b0000);
        check("reset_fall",  bus.fall,  4'b0000);
        chk_en = 1'b1;
        tick(3);
        bus.in_raw = 4'b0001;
        reset_n    = 1'b1;
        tick(20);
        check("idle_level", bus.level, 4'b0000);

        // clean step on channel 1
        bus.in_raw[1] = 1'b1;
        tick(5);
        check("step_pre_level", bus.level, 4'b0000);
        tick(1);
        check("step_level", bus.level, 4'b0010);
        check("step_rise",  bus.rise,  4'b0010);
        tick(1);
        check("step_rise_end", bus.rise, 4'b0000);

        // bounce on channel 2, then a steady high
        bus.in_raw[2] = 1'b1;
        tick(3);
        bus.in_raw[2] = 1'b0;
        tick(10);
        check("bounce_level", bus.level, 4'b0010);
        bus.in_raw[2] = 1'b1;
        tick(5);
        check("steady_pre_level", bus.level, 4'b0010);
        tick(1);
        check("steady_level", bus.level, 4'b0110);
        check("steady_rise",  bus.rise,  4'b0100);
        tick(4);

        // simultaneous events, channel 0 inverted
        bus.in_raw = 4'b1100;
        tick(5);
        check("simul_pre_level", bus.level, 4'b0110);
        tick(1);
        check("simul_level", bus.level, 4'b1101);
        check("simul_rise",  bus.rise,  4'b1001);
        check("simul_fall",  bus.fall,  4'b0010);
        tick(4);

        // clear while channel 3 is two counts into a pending fall
        bus.in_raw[3] = 1'b0;
        tick(4);
        bus.clear = 1'b1;
        tick(1);
        check("clear_level", bus.level, 4'b0101);
        check("clear_rise",  bus.rise,  4'b0000);
        check("clear_fall",  bus.fall,  4'b0000);
        bus.clear = 1'b0;
        tick(8);
        check("post_clear_level", bus.level, 4'b0101);

        // reset while channel 1 is pending a rise
        bus.in_raw[1] = 1'b1;
        tick(4);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_level", bus.level, 4'b0000);
        check("midreset_rise",  bus.rise,  4'b0000);
        check("midreset_fall",  bus.fall,  4'b0000);
        tick(1);
        reset_n = 1'b1;
        tick(10);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                c = $urandom_range(0, CH - 1);
                bus.in_raw[c] = ~bus.in_raw[c];
            end
            bus.clear = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 400) == 0) begin
                #2 reset_n = 1'b0;
                #1;
                check("rand_reset_level", bus.level, 4'b0000);
                tick(1);
                reset_n = 1'b1;
            end
            tick(1);
        end
        bus.clear = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
